// File: rtl/sr_link_pkg.sv
// Shared definitions for the byte-shift link (transmit and receive ends).
package sr_link_pkg;

    localparam int SR_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } sr_state_e;

    // Counter width able to hold 0..depth-1, never narrower than one bit.
    function automatic int sr_cnt_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_transmit_if.sv
// Producer load handshake plus link pins of the byte-shift transmitter.
interface sr_transmit_if #(parameter int M = 8);

    logic                               load_valid;
    logic                               load_ready;
    logic [M-1:0]                       data_in;
    logic                               abort;
    logic [sr_link_pkg::SR_BYTE_W-1:0]  byte_out;
    logic                               set_n;
    logic                               busy;
    logic                               done;

    modport master (
        output load_valid, data_in, abort,
        input  load_ready, byte_out, set_n, busy, done
    );

    modport slave (
        input  load_valid, data_in, abort,
        output load_ready, byte_out, set_n, busy, done
    );

endinterface

// File: rtl/sr_phase_timer.sv
// Loadable down-counter; tc is high once the loaded count has been consumed.
module sr_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/sr_transmit.sv
// Serializes an M-bit word into M/8 bytes, strobing set_n low once per byte.
module sr_transmit
    import sr_link_pkg::*;
#(
    parameter int M            = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int LOW_CYCLES   = 1
) (
    input  logic         clk,
    input  logic         rst,
    sr_transmit_if.slave bus
);

    localparam int N     = M / SR_BYTE_W;
    localparam int IDX_W = sr_cnt_w(N);
    localparam int PH_D  = (SETUP_CYCLES > LOW_CYCLES) ? SETUP_CYCLES : LOW_CYCLES;
    localparam int PH_W  = sr_cnt_w(PH_D);

    sr_state_e             state, state_n;
    logic [SR_BYTE_W-1:0]  byte_q, byte_n;
    logic                  set_n_q, set_n_n;
    logic                  ready_q, ready_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [M-1:0]          sh, sh_n, sh_shift;
    logic                  tmr_load, tmr_tc;
    logic [PH_W-1:0]       tmr_val;

    // Current byte always sits in sh[7:0]; shifting exposes the next one.
    assign sh_shift = sh >> SR_BYTE_W;

    sr_phase_timer #(.W(PH_W)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            byte_q  <= '0;
            set_n_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx     <= '0;
            sh      <= '0;
        end else begin
            state   <= state_n;
            byte_q  <= byte_n;
            set_n_q <= set_n_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            idx     <= idx_n;
            sh      <= sh_n;
        end
    end

    always_comb begin
        state_n  = state;
        byte_n   = byte_q;
        set_n_n  = set_n_q;
        ready_n  = ready_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        idx_n    = idx;
        sh_n     = sh;
        tmr_load = 1'b0;
        tmr_val  = '0;

        // Abort wins over both a strobe transition and frame completion.
        if (state != IDLE && bus.abort) begin
            state_n = IDLE;
            set_n_n = 1'b1;
            busy_n  = 1'b0;
            ready_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid && ready_q && !bus.abort) begin
                        sh_n     = bus.data_in;
                        byte_n   = bus.data_in[SR_BYTE_W-1:0];
                        set_n_n  = 1'b1;
                        ready_n  = 1'b0;
                        busy_n   = 1'b1;
                        idx_n    = '0;
                        state_n  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = PH_W'(SETUP_CYCLES - 1);
                    end
                end
                SETUP: begin
                    if (tmr_tc) begin
                        set_n_n  = 1'b0;
                        state_n  = STROBE;
                        tmr_load = 1'b1;
                        tmr_val  = PH_W'(LOW_CYCLES - 1);
                    end
                end
                STROBE: begin
                    if (tmr_tc) begin
                        set_n_n = 1'b1;
                        if (idx != IDX_W'(N - 1)) begin
                            idx_n    = idx + 1'b1;
                            sh_n     = sh_shift;
                            byte_n   = sh_shift[SR_BYTE_W-1:0];
                            state_n  = SETUP;
                            tmr_load = 1'b1;
                            tmr_val  = PH_W'(SETUP_CYCLES - 1);
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            ready_n = 1'b1;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    set_n_n = 1'b1;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end
            endcase
        end
    end

    assign bus.byte_out   = byte_q;
    assign bus.set_n      = set_n_q;
    assign bus.load_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: doc/sr_transmit.md
Name: sr_transmit

Overview:
- Serializes one M-bit word into M/8 bytes on an 8-bit bus with an active-low strobe `set_n`.
- It is the transmit end of the byte-shift link whose receiver shifts one byte in on each falling edge of `set`. The receiver places the newest byte at the top, so after M/8 strobes the first byte sent ends in bits [7:0].
- It sits between a word-level producer, using a valid/ready load, and the link pins.

Parameters:
- M, 8, word width in bits; must be a multiple of 8 and at least 8.
- SETUP_CYCLES, 1, clocks `byte_out` is held stable with `set_n` high before the falling edge; at least 1.
- LOW_CYCLES, 1, clocks `set_n` stays low per byte; at least 1.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset, asynchronous, active-low.
- load_valid, in, 1, producer offers `data_in`.
- load_ready, out, 1, block idle and able to accept a word.
- data_in, in, M, word to send; byte 0 = data_in[7:0].
- abort, in, 1, synchronous frame cancel.
- byte_out, out, 8, byte currently presented on the link.
- set_n, out, 1, link strobe; idle high, receiver samples on its falling edge.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle pulse when a frame completes normally.

Behaviour:
- All outputs are registered. Reset values (rst low, asynchronous): byte_out=0, set_n=1, load_ready=1, busy=0, done=0, state=IDLE, counters=0.
- N = M/8. Byte index counter is max(1, clog2(N)) bits. Phase counter is max(1, clog2(max(SETUP_CYCLES, LOW_CYCLES))) bits.
- States are IDLE, SETUP, STROBE.
- IDLE:
  - On load_valid & load_ready at edge T0: capture data_in into the shift register.
  - Same edge: byte_out=data_in[7:0], set_n=1, load_ready=0, busy=1, idx=0, state=SETUP.
  - data_in is ignored when not accepted.
- SETUP: after SETUP_CYCLES clocks in the state, set_n goes 0 and state=STROBE. byte_out is unchanged.
- STROBE: after LOW_CYCLES clocks, set_n goes 1 on the same edge, then:
  - If idx<N-1: idx+1, byte_out = next byte (byte idx+1 of the captured word), state=SETUP.
  - Else: state=IDLE, busy=0, load_ready=1, done=1 for exactly one cycle, byte_out holds the last byte.
- byte_out changes only on edges where set_n is 1 after the edge. It never changes while set_n is low or on the edge that drives set_n low.
- Frame timing: the accept edge is T0 and k is the byte index 0..N-1.
  - Falling edge of set_n for byte k: T0 + k·(SETUP_CYCLES+LOW_CYCLES) + SETUP_CYCLES.
  - done asserts after edge T0 + N·(SETUP_CYCLES+LOW_CYCLES).
- Throughput: the next word can be accepted no earlier than the edge following the one that raised done. Minimum word period is N·(S+L)+1 clocks.
- load_valid while busy has no effect; the producer must hold it.
- abort:
  - Sampled on an edge while busy: set_n=1, state=IDLE, busy=0, load_ready=1, done stays 0, byte_out holds.
  - abort takes priority over a completion on the same edge.
  - abort while IDLE: ignored, and it blocks acceptance on that edge.
  - The receiver is left partially shifted; clearing it is the system's responsibility.
- Reset asserted mid-frame: immediate return to reset values, set_n high without a further falling edge.
- Reset deasserted: first possible accept is on the first rising edge with rst high.
- N=1 (M=8): single byte, idx never increments.

Decomposition:
- Shared package sr_link_pkg holds:
  - SR_BYTE_W=8;
  - state encodings (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2);
  - a function giving counter width for a given depth, shared with the receive side.
- Optional sub-module sr_phase_timer: loadable down-counter with a terminal-count flag, used for both the SETUP and STROBE durations. Everything else is inline.

Test Plan:
- Basic frame (M=32, S=1, L=1): load 0xA1B2C3D4 at edge 0.
  - byte_out at the set_n falls on edges 1, 3, 5, 7 is D4, C3, B2, A1.
  - done pulses after edge 8; load_ready=1 on the same cycle.
- Loopback: sr_transmit (M=32, S=2, L=3) drives a receiver with matching M, with `set` = set_n.
  - Send 0x01234567 then 0xFEDCBA98 with load_valid held high.
  - Receiver out equals each word after its done; word period is 21 clocks.
- Stability: assertion that byte_out never changes while set_n=0 or on a 1->0 edge, across 200 random words with random S, L in 1..4.
- Abort: abort asserted after byte 1's fall (M=32).
  - Exactly 2 falling edges on set_n, no done, load_ready=1 next cycle.
  - A new word is then sent correctly.
- Reset mid-STROBE: rst low while set_n=0.
  - set_n=1, busy=0, byte_out=0 asynchronously.
  - No glitch fall after release.
- M=8: load 0x5A, one fall with byte_out=0x5A, done after S+L edges; load_valid while busy is ignored.
